dds_cfg_ctrl: RTL
=================

Name: dds_cfg_ctrl

Overview:
- Configuration controller for the phase_acc DDS datapath.
- Accepts a stream of 16-bit command words over a valid/ready port and decodes each one.
- Maintains the freq0/freq1 FTW registers, the phase0/phase1 offset registers, the freq_sel/phase_sel selects and a stretched synchronous accumulator reset, all driving phase_acc directly.
- Sits between the host-side interface (SPI/UART bridge) and phase_acc.

Parameters:
- RST_HOLD, 4: cycles acc_reset stays high after the control RESET bit clears, and after async reset release; range 1..255.
- FREQ0_INIT, 28'h0: reset value of freq0_set.
- FREQ1_INIT, 28'h0: reset value of freq1_set.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_valid  in  1  command word valid
- wr_ready  out  1  controller can accept a word
- wr_data  in  16  command word
- freq0_set  out  28  FTW register 0, to phase_acc
- freq1_set  out  28  FTW register 1, to phase_acc
- phase0_set  out  12  phase offset register 0
- phase1_set  out  12  phase offset register 1
- freq_sel  out  1  FTW select
- phase_sel  out  1  phase select
- acc_reset  out  1  synchronous active-high reset to phase_acc
- err_seq  out  1  one-cycle pulse on a B28 sequence violation

Behaviour:
- Reset values:
  - freq0_set=FREQ0_INIT, freq1_set=FREQ1_INIT.
  - phase0/1_set=0; freq_sel=phase_sel=0; err_seq=0; wr_ready=0.
  - B28=0, HLB=0, ctrl RESET bit=0.
  - acc_reset=1; hold counter loaded with RST_HOLD; state IDLE.
- wr_ready:
  - Registered; 1 from the first clock after reset release.
  - Remains 1 thereafter, so one word is accepted per cycle.
  - A word is accepted when wr_valid && wr_ready.
- Decode of wr_data[15:14]:
  - 00 = control word:
    - D13=B28, D12=HLB, D11=FSELECT, D10=PSELECT, D8=RESET.
    - Other bits are ignored.
    - freq_sel/phase_sel/B28/HLB/RESET update the cycle after accept.
  - 01 = FREQ0 data, 10 = FREQ1 data; payload is D13:0.
  - 11 = phase word:
    - D13 selects PHASE1 (1) or PHASE0 (0); D11:0 is the payload.
    - D12 is ignored.
    - The selected register loads the cycle after accept.
- Frequency writes with B28=0:
  - HLB=1 replaces FTW[27:14]; HLB=0 replaces FTW[13:0].
  - Takes effect the cycle after accept.
- Frequency writes with B28=1 use the FSM:
  - IDLE: a freq word latches D13:0 into lsb_hold and records target (0/1) -> WAIT_MSB. Outputs are unchanged.
  - WAIT_MSB + freq word to the same target: the FTW becomes {D13:0, lsb_hold}, committed atomically the cycle after accept -> IDLE.
  - WAIT_MSB + any other word (freq word to the other register, control word, phase word):
    - Pulse err_seq for 1 cycle.
    - Discard lsb_hold and go to IDLE.
    - The new word is then processed as if received in IDLE; a freq word to the other target goes straight to WAIT_MSB.
  - A control word clearing B28 while in WAIT_MSB is covered by the rule above: error, then the control word is applied.
- acc_reset:
  - 1 while ctrl RESET=1.
  - When RESET clears, the counter reloads RST_HOLD and decrements each cycle; acc_reset=0 once it reaches 0.
  - A RESET=1 write during the countdown reasserts and reloads.
  - Register writes are accepted normally while acc_reset=1.
- Simultaneous events: async reset dominates and aborts WAIT_MSB; lsb_hold is cleared.
- No arithmetic beyond concatenation; all widths are exact, with no truncation.

Optional Feature:
- Macro: DDS_CFG_ERRCNT_EN
- Defined:
  - Adds output err_count[7:0].
  - Resets to 0; increments on each err_seq pulse; saturates at 8'hFF.
  - Cleared by a control word with D0=1.
- Undefined: the port and counter are absent; D0 is ignored.

Decomposition:
- Package dds_cfg_pkg holds:
  - opcode constants (OP_CTRL=2'b00, OP_FREQ0=2'b01, OP_FREQ1=2'b10, OP_PHASE=2'b11);
  - control bit indices (B28_BIT=13, HLB_BIT=12, FSEL_BIT=11, PSEL_BIT=10, RST_BIT=8, ERRCLR_BIT=0);
  - FTW_W=28, HALF_W=14, PHASE_W=12;
  - FSM state encoding.
- Sub-module dds_rst_stretch: acc_reset hold counter with reload.

Test Plan:
- Reset release, then idle -> acc_reset high for exactly 4 cycles after release; all registers equal INIT/0; wr_ready=1 one cycle after release.
- Write 0x2000, then 0x67C6 -> freq0_set unchanged. Then 0x4002 -> freq0_set=28'h000A7C6 the next cycle, with no intermediate value visible.
- B28=1: write 0x8F8C, 0x8005 -> freq1_set=28'h0014F8C. Then write 0xE3FF, 0x2C00 -> phase1_set=12'h3FF, freq_sel=1, phase_sel=1.
- B28=1: write 0x67C6, then 0x8005 -> err_seq pulses 1 cycle; freq0_set unchanged; FSM holds a FREQ1 LSB of 0x0005. Then write 0x8001 -> freq1_set=28'h0004005.
- Write 0x0000 (B28=0), then 0x5001 with HLB=1 via 0x1000 first -> freq0_set[27:14]=14'h1001 and [13:0] retained.
- Write 0x2100, wait 3 cycles, write 0x2000 -> acc_reset stays high through 4 cycles after the clear. Async reset mid-WAIT_MSB -> FSM returns to IDLE and no commit occurs.

Source files
------------

// File: rtl/dds_cfg_pkg.sv
// Shared definitions for the DDS configuration controller: command opcodes,
// control-word bit positions, register widths and the B28 sequencing FSM.
package dds_cfg_pkg;

    localparam int CMD_W   = 16;
    localparam int FTW_W   = 28;
    localparam int HALF_W  = 14;
    localparam int PHASE_W = 12;
    localparam int HOLD_W  = 8;

    // Command opcodes carried in wr_data[15:14]
    localparam logic [1:0] OP_CTRL  = 2'b00;
    localparam logic [1:0] OP_FREQ0 = 2'b01;
    localparam logic [1:0] OP_FREQ1 = 2'b10;
    localparam logic [1:0] OP_PHASE = 2'b11;

    // Control-word bit positions
    localparam int B28_BIT    = 13;
    localparam int HLB_BIT    = 12;
    localparam int FSEL_BIT   = 11;
    localparam int PSEL_BIT   = 10;
    localparam int RST_BIT    = 8;
    localparam int ERRCLR_BIT = 0;

    // Phase word: D13 picks PHASE1 over PHASE0
    localparam int PHSEL_BIT  = 13;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MSB = 1'b1
    } cfg_state_e;

    // Latched control-word fields
    typedef struct packed {
        logic b28;
        logic hlb;
        logic fsel;
        logic psel;
        logic rst;
    } ctrl_t;

    // Replace one 14-bit half of an FTW, keeping the other half intact
    function automatic logic [FTW_W-1:0] merge_half(
        input logic [FTW_W-1:0]  ftw,
        input logic              upper,
        input logic [HALF_W-1:0] half
    );
        merge_half = upper ? {half, ftw[HALF_W-1:0]} : {ftw[FTW_W-1:HALF_W], half};
    endfunction

endpackage

// File: rtl/dds_cfg_ctrl_rst_stretch.sv
// dds_rst_stretch: stretches the accumulator reset. While hold is high the
// counter sits at RST_HOLD; once hold drops it counts down and acc_reset
// stays high until the count reaches zero.
module dds_rst_stretch
    import dds_cfg_pkg::*;
#(
    parameter int unsigned RST_HOLD = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic hold,
    output logic acc_reset
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    // Reload while held, otherwise count down to zero and stay there
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (hold) begin
            cnt_d = HOLD_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, preloaded so acc_reset is high straight out of reset
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            cnt_q <= HOLD_LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign acc_reset = hold || (cnt_q != '0);

endmodule

// File: rtl/dds_cfg_ctrl.sv
// dds_cfg_ctrl: decodes 16-bit command words into the phase_acc FTW, phase
// offset and select registers, with B28 two-word atomic FTW writes and a
// stretched accumulator reset.
// Optional: define DDS_CFG_ERRCNT_EN to add the saturating err_count output.
module dds_cfg_ctrl
    import dds_cfg_pkg::*;
#(
    parameter int unsigned       RST_HOLD   = 4,
    parameter logic [FTW_W-1:0]  FREQ0_INIT = '0,
    parameter logic [FTW_W-1:0]  FREQ1_INIT = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [CMD_W-1:0]   wr_data,
    output logic [FTW_W-1:0]   freq0_set,
    output logic [FTW_W-1:0]   freq1_set,
    output logic [PHASE_W-1:0] phase0_set,
    output logic [PHASE_W-1:0] phase1_set,
    output logic               freq_sel,
    output logic               phase_sel,
    output logic               acc_reset,
    output logic               err_seq
`ifdef DDS_CFG_ERRCNT_EN
    ,
    output logic [7:0]         err_count
`endif
);

    cfg_state_e         state_q, state_d;
    logic               tgt_q, tgt_d;
    logic [HALF_W-1:0]  lsb_hold_q, lsb_hold_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [FTW_W-1:0]   freq0_q, freq0_d;
    logic [FTW_W-1:0]   freq1_q, freq1_d;
    logic [PHASE_W-1:0] phase0_q, phase0_d;
    logic [PHASE_W-1:0] phase1_q, phase1_d;
    logic               err_seq_q, err_seq_d;
    logic               wr_ready_q, wr_ready_d;

    logic              accept;
    logic [1:0]        op;
    logic [HALF_W-1:0] payload;
    logic              is_freq;
    logic              word_tgt;
    logic              msb_match;

    assign accept    = wr_valid && wr_ready_q;
    assign op        = wr_data[15:14];
    assign payload   = wr_data[HALF_W-1:0];
    assign is_freq   = (op == OP_FREQ0) || (op == OP_FREQ1);
    assign word_tgt  = (op == OP_FREQ1);
    assign msb_match = (state_q == WAIT_MSB) && is_freq && (word_tgt == tgt_q);

    // Command decode: B28 sequencing, register updates and error detection
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        lsb_hold_d = lsb_hold_q;
        ctrl_d     = ctrl_q;
        freq0_d    = freq0_q;
        freq1_d    = freq1_q;
        phase0_d   = phase0_q;
        phase1_d   = phase1_q;
        err_seq_d  = 1'b0;
        wr_ready_d = 1'b1;

        if (accept) begin
            if (msb_match) begin
                // Second half of a B28 pair: commit the whole FTW at once
                if (tgt_q) begin
                    freq1_d = {payload, lsb_hold_q};
                end else begin
                    freq0_d = {payload, lsb_hold_q};
                end
                state_d    = IDLE;
                lsb_hold_d = '0;
            end else begin
                // Anything other than the matching MSB breaks the pair; the
                // word is then handled as if the FSM were idle.
                if (state_q == WAIT_MSB) begin
                    err_seq_d  = 1'b1;
                    state_d    = IDLE;
                    lsb_hold_d = '0;
                end
                case (op)
                    OP_CTRL: begin
                        ctrl_d.b28  = wr_data[B28_BIT];
                        ctrl_d.hlb  = wr_data[HLB_BIT];
                        ctrl_d.fsel = wr_data[FSEL_BIT];
                        ctrl_d.psel = wr_data[PSEL_BIT];
                        ctrl_d.rst  = wr_data[RST_BIT];
                    end
                    OP_FREQ0, OP_FREQ1: begin
                        if (ctrl_q.b28) begin
                            lsb_hold_d = payload;
                            tgt_d      = word_tgt;
                            state_d    = WAIT_MSB;
                        end else if (word_tgt) begin
                            freq1_d = merge_half(freq1_q, ctrl_q.hlb, payload);
                        end else begin
                            freq0_d = merge_half(freq0_q, ctrl_q.hlb, payload);
                        end
                    end
                    OP_PHASE: begin
                        if (wr_data[PHSEL_BIT]) begin
                            phase1_d = wr_data[PHASE_W-1:0];
                        end else begin
                            phase0_d = wr_data[PHASE_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Controller state and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tgt_q      <= 1'b0;
            lsb_hold_q <= '0;
            ctrl_q     <= '0;
            freq0_q    <= FREQ0_INIT;
            freq1_q    <= FREQ1_INIT;
            phase0_q   <= '0;
            phase1_q   <= '0;
            err_seq_q  <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            lsb_hold_q <= lsb_hold_d;
            ctrl_q     <= ctrl_d;
            freq0_q    <= freq0_d;
            freq1_q    <= freq1_d;
            phase0_q   <= phase0_d;
            phase1_q   <= phase1_d;
            err_seq_q  <= err_seq_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    // The cycle before wr_ready rises is treated like RESET=1, so leaving
    // async reset and clearing the RESET bit stretch acc_reset identically.
    logic rst_hold;
    assign rst_hold = ctrl_q.rst || !wr_ready_q;

    dds_rst_stretch #(
        .RST_HOLD (RST_HOLD)
    ) u_rst_stretch (
        .clock     (clock),
        .reset     (reset),
        .hold      (rst_hold),
        .acc_reset (acc_reset)
    );

`ifdef DDS_CFG_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Saturating error counter; a control word with D0 set clears it, and
    // the clear wins because that word is applied after the error it caused.
    always_comb begin
        err_count_d = err_count_q;
        if (err_seq_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
        if (accept && (op == OP_CTRL) && wr_data[ERRCLR_BIT]) begin
            err_count_d = '0;
        end
    end

    // Error counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    assign wr_ready   = wr_ready_q;
    assign freq0_set  = freq0_q;
    assign freq1_set  = freq1_q;
    assign phase0_set = phase0_q;
    assign phase1_set = phase1_q;
    assign freq_sel   = ctrl_q.fsel;
    assign phase_sel  = ctrl_q.psel;
    assign err_seq    = err_seq_q;

endmodule
